row_skew_buf: RTL and testbench

//  Row input skew buffer between input-memory read path and systolic array west edge.

---
 rtl/row_skew_buf_if.sv | 25 ++
 rtl/row_skew_buf.sv | 86 ++++++++
 tb/tb_row_skew_buf.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/row_skew_buf_if.sv
// Vector handshake and skewed-output bundle between the input-memory read path,
// the row skew buffer and the systolic array west edge.
interface row_skew_buf_if #(
  parameter int WORD_LEN = 8,
  parameter int ROWS     = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_last;
  logic [ROWS*WORD_LEN-1:0] in_dat;
  logic [ROWS*WORD_LEN-1:0] out_dat;
  logic [ROWS-1:0]          out_vld;
  logic                     out_last;
  logic                     busy;

  modport master (
    output in_valid, in_last, in_dat,
    input  in_ready, out_dat, out_vld, out_last, busy
  );

  modport slave (
    input  in_valid, in_last, in_dat,
    output in_ready, out_dat, out_vld, out_last, busy
  );
endinterface

// File: rtl/row_skew_buf.sv
// Row input skew buffer: row r is delayed by r extra cycles to form the diagonal
// wavefront for the systolic array; the skew pipeline is drained at end of tile.
module row_skew_buf #(
  parameter int WORD_LEN = 8,
  parameter int ROWS     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  row_skew_buf_if.slave     bus
);
  localparam int CNT_W = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             r_last [ROWS];

  assign bus.in_ready = en & (r_state != DRAIN);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign bus.busy     = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (en) begin
      case (r_state)
        IDLE, STREAM: begin
          if (w_accept) begin
            if (bus.in_last) begin
              r_state <= DRAIN;
              r_cnt   <= CNT_W'(ROWS - 1);
            end else begin
              r_state <= STREAM;
            end
          end
        end
        DRAIN: begin
          // Exit lands on the edge where the last beat reaches row ROWS-1.
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Per-row shift registers: row r holds r+1 stages, output is the deepest one.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [WORD_LEN-1:0] r_dat [r+1];
    logic                r_vld [r+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) begin
          r_dat[i] <= '0;
          r_vld[i] <= 1'b0;
        end
      end else if (en) begin
        r_dat[0] <= w_accept ? bus.in_dat[r*WORD_LEN +: WORD_LEN] : '0;
        r_vld[0] <= w_accept;
        for (int i = 1; i <= r; i++) begin
          r_dat[i] <= r_dat[i-1];
          r_vld[i] <= r_vld[i-1];
        end
      end
    end

    assign bus.out_dat[r*WORD_LEN +: WORD_LEN] = r_dat[r];
    assign bus.out_vld[r]                      = r_vld[r];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) r_last[i] <= 1'b0;
    end else if (en) begin
      r_last[0] <= w_accept & bus.in_last;
      for (int i = 1; i < ROWS; i++) r_last[i] <= r_last[i-1];
    end
  end

  assign bus.out_last = r_last[ROWS-1];
endmodule

// File: tb/tb_row_skew_buf.sv
// Directed bench for row_skew_buf with ROWS=4, WORD_LEN=8: reset, skew, drain
// handshake, gaps, stall and reset during drain.
module tb_row_skew_buf;
  localparam int WORD_LEN = 8;
  localparam int ROWS     = 4;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   n_chk  = 0;
  int   n_pass = 0;

  row_skew_buf_if #(.WORD_LEN(WORD_LEN), .ROWS(ROWS)) bus();

  row_skew_buf #(.WORD_LEN(WORD_LEN), .ROWS(ROWS)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] row(input int r);
    return bus.out_dat[r*WORD_LEN +: WORD_LEN];
  endfunction

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    bus.in_dat   = 32'hAABBCCDD;

    // Reset held two cycles with in_valid asserted
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_vld",   {28'd0, bus.out_vld}, 32'h0);
      check("rst_dat",   bus.out_dat, 32'h0);
      check("rst_last",  {31'd0, bus.out_last}, 32'h0);
      check("rst_busy",  {31'd0, bus.busy}, 32'h0);
      check("rst_ready", {31'd0, bus.in_ready}, 32'h0);
    end
    rst = 1'b0;
    en  = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, bus.in_ready}, 32'h1);

    // Skew: two-beat tile
    bus.in_valid = 1'b1;
    bus.in_dat   = 32'h13121110;
    tick(); // edge1
    check("e1_row0", {24'd0, row(0)}, 32'h10);
    check("e1_vld",  {28'd0, bus.out_vld}, 32'h1);
    check("e1_busy", {31'd0, bus.busy}, 32'h1);
    bus.in_dat  = 32'h23222120;
    bus.in_last = 1'b1;
    tick(); // edge2 -> DRAIN
    check("e2_row0", {24'd0, row(0)}, 32'h20);
    check("e2_row1", {24'd0, row(1)}, 32'h11);
    check("e2_vld",  {28'd0, bus.out_vld}, 32'h3);
    check("e2_ready", {31'd0, bus.in_ready}, 32'h0);
    // Next vector held valid through the drain
    bus.in_dat  = 32'h33323130;
    bus.in_last = 1'b0;
    tick(); // edge3
    check("e3_row1", {24'd0, row(1)}, 32'h21);
    check("e3_row2", {24'd0, row(2)}, 32'h12);
    check("e3_vld",  {28'd0, bus.out_vld}, 32'h6);
    check("e3_ready", {31'd0, bus.in_ready}, 32'h0);
    tick(); // edge4
    check("e4_row3", {24'd0, row(3)}, 32'h13);
    check("e4_vld",  {28'd0, bus.out_vld}, 32'hC);
    check("e4_last", {31'd0, bus.out_last}, 32'h0);
    check("e4_ready", {31'd0, bus.in_ready}, 32'h0);
    tick(); // edge5
    check("e5_row3", {24'd0, row(3)}, 32'h23);
    check("e5_last", {31'd0, bus.out_last}, 32'h1);
    check("e5_vld",  {28'd0, bus.out_vld}, 32'h8);
    check("e5_busy", {31'd0, bus.busy}, 32'h0);
    check("e5_ready", {31'd0, bus.in_ready}, 32'h1);
    tick(); // edge6: held vector accepted on the 4th cycle
    check("e6_row0", {24'd0, row(0)}, 32'h30);
    check("e6_last", {31'd0, bus.out_last}, 32'h0);
    check("e6_vld",  {28'd0, bus.out_vld}, 32'h1);
    check("e6_busy", {31'd0, bus.busy}, 32'h1);

    // Gaps: valid pattern 1 (edge6), 0, 1
    bus.in_valid = 1'b0;
    tick(); // edge7
    check("e7_vld0", {31'd0, bus.out_vld[0]}, 32'h0);
    check("e7_row0", {24'd0, row(0)}, 32'h0);
    bus.in_valid = 1'b1;
    bus.in_dat   = 32'h43424140;
    tick(); // edge8
    check("e8_row0", {24'd0, row(0)}, 32'h40);
    check("e8_vld",  {28'd0, bus.out_vld}, 32'h5);
    bus.in_valid = 1'b0;
    tick(); // edge9
    check("e9_row3", {24'd0, row(3)}, 32'h33);
    check("e9_vld",  {28'd0, bus.out_vld}, 32'hA);

    // Stall three cycles with a last beat offered
    en           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_dat   = 32'h53525150;
    bus.in_last  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", {31'd0, bus.in_ready}, 32'h0);
      tick();
      check("stall_vld",  {28'd0, bus.out_vld}, 32'hA);
      check("stall_row3", {24'd0, row(3)}, 32'h33);
      check("stall_row1", {24'd0, row(1)}, 32'h41);
      check("stall_busy", {31'd0, bus.busy}, 32'h1);
    end
    en = 1'b1;
    tick(); // accept last beat -> DRAIN
    check("s1_row0", {24'd0, row(0)}, 32'h50);
    check("s1_row2", {24'd0, row(2)}, 32'h42);
    check("s1_vld",  {28'd0, bus.out_vld}, 32'h5);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
    check("s2_row3", {24'd0, row(3)}, 32'h43);
    check("s2_vld3", {31'd0, bus.out_vld[3]}, 32'h1);
    tick();
    check("s3_vld3", {31'd0, bus.out_vld[3]}, 32'h0);
    check("s3_last", {31'd0, bus.out_last}, 32'h0);
    tick();
    check("s4_row3", {24'd0, row(3)}, 32'h53);
    check("s4_last", {31'd0, bus.out_last}, 32'h1);
    check("s4_busy", {31'd0, bus.busy}, 32'h0);
    tick();
    check("s5_last", {31'd0, bus.out_last}, 32'h0);

    // Reset in DRAIN with cnt=2
    bus.in_valid = 1'b1;
    bus.in_dat   = 32'h63626160;
    tick();
    bus.in_dat  = 32'h73727170;
    bus.in_last = 1'b1;
    tick(); // DRAIN, cnt=3
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick(); // cnt=2
    check("rd_busy", {31'd0, bus.busy}, 32'h1);
    rst = 1'b1;
    tick();
    check("rd_vld",  {28'd0, bus.out_vld}, 32'h0);
    check("rd_dat",  bus.out_dat, 32'h0);
    check("rd_busy2", {31'd0, bus.busy}, 32'h0);
    rst = 1'b0;
    #1;
    check("rd_ready", {31'd0, bus.in_ready}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rd_nolast", {31'd0, bus.out_last}, 32'h0);
      check("rd_novld",  {28'd0, bus.out_vld}, 32'h0);
    end

    // Fresh single-beat tile
    bus.in_valid = 1'b1;
    bus.in_dat   = 32'h83828180;
    bus.in_last  = 1'b1;
    tick();
    check("f1_row0", {24'd0, row(0)}, 32'h80);
    check("f1_busy", {31'd0, bus.busy}, 32'h1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    tick();
    check("f2_row1", {24'd0, row(1)}, 32'h81);
    tick();
    check("f3_row2", {24'd0, row(2)}, 32'h82);
    check("f3_last", {31'd0, bus.out_last}, 32'h0);
    tick();
    check("f4_row3", {24'd0, row(3)}, 32'h83);
    check("f4_last", {31'd0, bus.out_last}, 32'h1);
    check("f4_busy", {31'd0, bus.busy}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
